// File: rtl/bk_digit_subtractor_pkg.sv
// Shared types and sizing helpers for the digit-serial Brent-Kung operand-recovery subtractor.
package bk_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int BK_WIDTH = 12;
    localparam int BK_DIGIT = 2;

    // Beats needed to cover the WIDTH+1-bit minuend: ceil((width+1)/digit).
    function automatic int bk_nb(input int width, input int digit);
        return (width + digit) / digit;
    endfunction

    function automatic int bk_cnt_w(input int nb);
        return (nb > 1) ? $clog2(nb) : 1;
    endfunction

endpackage

// File: rtl/bk_digit_subtractor_sub_digit.sv
// Combinational DIGIT-bit ripple subtractor: d = a - b - bin, bout = borrow out of the MSB.
module bk_sub_digit #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             bin,
    output logic [DIGIT-1:0] d,
    output logic             bout
);

    logic [DIGIT:0] w_borrow;

    // NOTE: every output of a combinational block is assigned on every path, so no latch can be inferred.
    always_comb begin
        w_borrow[0] = bin;
        for (int i = 0; i < DIGIT; i++) begin
            d[i]          = a[i] ^ b[i] ^ w_borrow[i];
            w_borrow[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & w_borrow[i]);
        end
        bout = w_borrow[DIGIT];
    end

endmodule

// File: rtl/bk_digit_subtractor.sv
// Digit-serial B = sum - A recovery stage with valid/ready on both sides.
// Optional macro BK_SUB_SAT_EN: clamp diff_o to zero when the final borrow is set.
module bk_digit_subtractor
    import bk_pkg::*;
#(
    parameter int WIDTH = BK_WIDTH,
    parameter int DIGIT = BK_DIGIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:0]   sum_i,
    input  logic [WIDTH-1:0] opa_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   diff_o,
    output logic             borrow_o
);

    localparam int W1 = WIDTH + 1;
    localparam int NB = bk_nb(WIDTH, DIGIT);
    localparam int PW = NB * DIGIT;
    localparam int CW = bk_cnt_w(NB);
    localparam logic [CW-1:0] LAST_BEAT = CW'(NB - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [PW-1:0]   r_a;
    logic [PW-1:0]   r_b;
    logic [PW-1:0]   r_res;
    logic            r_borrow;
    logic [W1-1:0]   r_diff;
    logic            r_bout;

    logic [DIGIT-1:0] w_d;
    logic             w_bout;
    logic [PW-1:0]    w_res_nxt;
    logic [W1-1:0]    w_diff_fin;
    logic             w_last;

    bk_sub_digit #(.DIGIT(DIGIT)) u_sub_digit (
        .a    (r_a[DIGIT-1:0]),
        .b    (r_b[DIGIT-1:0]),
        .bin  (r_borrow),
        .d    (w_d),
        .bout (w_bout)
    );

    assign w_last    = (r_cnt == LAST_BEAT);
    assign w_res_nxt = (r_res >> DIGIT) | (PW'(w_d) << (PW - DIGIT));

    // Padding digits are 0 - 0, so the borrow out of bit WIDTH passes through them unchanged.
`ifdef BK_SUB_SAT_EN
    assign w_diff_fin = w_bout ? '0 : w_res_nxt[W1-1:0];
`else
    assign w_diff_fin = w_res_nxt[W1-1:0];
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_state_nxt = RUN;
            RUN:     if (w_last)    w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default:                w_state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; all registers, shift registers
    // included, are ordinary flops and clear on the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_borrow <= 1'b0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: if (in_valid) begin
                    r_a      <= PW'(sum_i);
                    r_b      <= PW'(opa_i);
                    r_borrow <= 1'b0;
                    r_cnt    <= '0;
                end
                RUN: begin
                    r_a      <= r_a >> DIGIT;
                    r_b      <= r_b >> DIGIT;
                    r_res    <= w_res_nxt;
                    r_borrow <= w_bout;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_diff <= w_diff_fin;
                        r_bout <= w_bout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign diff_o    = r_diff;
    assign borrow_o  = r_bout;

endmodule
